// File: rtl/vga_pkg.sv
// Shared VGA definitions: default timing/colour widths and the screen-mux state type.
package vga_pkg;

    typedef enum logic [1:0] {SHOW, PENDING, BLANK} mux_state_t;

    localparam int VGA_HC_W  = 11;
    localparam int VGA_VC_W  = 11;
    localparam int VGA_RGB_W = 12;

endpackage

// File: rtl/vga_screen_mux_if.sv
// Bundle of the screen mux's timing, source and output signals; master drives sources, slave is the mux.
interface vga_screen_mux_if import vga_pkg::*; #(
    parameter int N_SCREENS = 4,
    parameter int HC_W      = VGA_HC_W,
    parameter int VC_W      = VGA_VC_W,
    parameter int RGB_W     = VGA_RGB_W
);
    localparam int SEL_W = $clog2(N_SCREENS + 1);

    logic [SEL_W-1:0]           sel;
    logic [HC_W-1:0]            in_hcount;
    logic [VC_W-1:0]            in_vcount;
    logic                       in_hsync;
    logic                       in_vsync;
    logic                       in_hblnk;
    logic                       in_vblnk;
    logic [N_SCREENS*HC_W-1:0]  src_hcount;
    logic [N_SCREENS*VC_W-1:0]  src_vcount;
    logic [N_SCREENS-1:0]       src_hsync;
    logic [N_SCREENS-1:0]       src_vsync;
    logic [N_SCREENS-1:0]       src_hblnk;
    logic [N_SCREENS-1:0]       src_vblnk;
    logic [N_SCREENS*RGB_W-1:0] src_rgb;
    logic [HC_W-1:0]            out_hcount;
    logic [VC_W-1:0]            out_vcount;
    logic                       out_hsync;
    logic                       out_vsync;
    logic                       out_hblnk;
    logic                       out_vblnk;
    logic [RGB_W-1:0]           out_rgb;
    logic                       busy;
    logic                       switch_done;

    modport master (
        output sel, in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk,
        output src_hcount, src_vcount, src_hsync, src_vsync, src_hblnk, src_vblnk, src_rgb,
        input  out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb,
        input  busy, switch_done
    );

    modport slave (
        input  sel, in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk,
        input  src_hcount, src_vcount, src_hsync, src_vsync, src_hblnk, src_vblnk, src_rgb,
        output out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb,
        output busy, switch_done
    );

endinterface

// File: rtl/vga_frame_tick.sv
// Flags the first pixel of every frame from the reference timing counters.
module vga_frame_tick #(
    parameter int HC_W = 11,
    parameter int VC_W = 11
) (
    input  logic [HC_W-1:0] i_hcount,
    input  logic [VC_W-1:0] i_vcount,
    output logic            o_frameTick
);

    assign o_frameTick = (i_hcount == '0) && (i_vcount == '0);

endmodule

// File: rtl/vga_screen_mux.sv
// Frame-synchronous VGA source selector: switches only on frame boundaries and then
// inserts BLANK_FRAMES black frames before the new screen is shown.
module vga_screen_mux import vga_pkg::*; #(
    parameter int               N_SCREENS    = 4,
    parameter int               HC_W         = VGA_HC_W,
    parameter int               VC_W         = VGA_VC_W,
    parameter int               RGB_W        = VGA_RGB_W,
    parameter int               BLANK_FRAMES = 2,
    parameter logic [RGB_W-1:0] DEFAULT_RGB  = '0
) (
    input  logic             clk,
    input  logic             rst,
    vga_screen_mux_if.slave  bus
);

    localparam int               SEL_W      = $clog2(N_SCREENS + 1);
    localparam int               IDX_W      = $clog2(N_SCREENS);
    localparam logic [SEL_W-1:0] N_SEL      = SEL_W'(N_SCREENS);
    localparam logic [7:0]       BLANK_LOAD = 8'(BLANK_FRAMES);

    mux_state_t       r_state, w_nextState;
    logic [SEL_W-1:0] r_activeSel, w_activeSelNext;
    logic [SEL_W-1:0] r_targetSel, w_targetSelNext;
    logic [7:0]       r_frameCnt, w_frameCntNext;
    logic             w_switchDone;
    logic             w_frameTick;

    logic             w_inRange;
    logic [IDX_W-1:0] w_chan;
    logic [HC_W-1:0]  w_hcount;
    logic [VC_W-1:0]  w_vcount;
    logic             w_hsync, w_vsync, w_hblnk, w_vblnk;
    logic [RGB_W-1:0] w_rgb;

    logic [HC_W-1:0]  r_hcount;
    logic [VC_W-1:0]  r_vcount;
    logic             r_hsync, r_vsync, r_hblnk, r_vblnk;
    logic [RGB_W-1:0] r_rgb;
    logic             r_busy, r_switchDone;

    vga_frame_tick #(
        .HC_W (HC_W),
        .VC_W (VC_W)
    ) u_frameTick (
        .i_hcount    (bus.in_hcount),
        .i_vcount    (bus.in_vcount),
        .o_frameTick (w_frameTick)
    );

    // Out-of-range selections fall back to the reference timing; the channel index
    // is forced to 0 there so the slice never leaves the packed source vectors.
    always_comb begin
        w_inRange = (r_activeSel < N_SEL);
        w_chan    = w_inRange ? IDX_W'(r_activeSel) : '0;
        w_hcount  = bus.in_hcount;
        w_vcount  = bus.in_vcount;
        w_hsync   = bus.in_hsync;
        w_vsync   = bus.in_vsync;
        w_hblnk   = bus.in_hblnk;
        w_vblnk   = bus.in_vblnk;
        if (w_inRange) begin
            w_hcount = bus.src_hcount[w_chan*HC_W +: HC_W];
            w_vcount = bus.src_vcount[w_chan*VC_W +: VC_W];
            w_hsync  = bus.src_hsync[w_chan];
            w_vsync  = bus.src_vsync[w_chan];
            w_hblnk  = bus.src_hblnk[w_chan];
            w_vblnk  = bus.src_vblnk[w_chan];
        end
        if (w_hblnk || w_vblnk || (r_state == BLANK)) begin
            w_rgb = '0;
        end else if (!w_inRange) begin
            w_rgb = DEFAULT_RGB;
        end else begin
            w_rgb = bus.src_rgb[w_chan*RGB_W +: RGB_W];
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_activeSelNext = r_activeSel;
        w_targetSelNext = r_targetSel;
        w_frameCntNext  = r_frameCnt;
        w_switchDone    = 1'b0;
        case (r_state)
            SHOW: begin
                if (bus.sel != r_activeSel) begin
                    w_targetSelNext = bus.sel;
                    w_nextState     = PENDING;
                end
            end
            PENDING: begin
                w_targetSelNext = bus.sel;
                if (bus.sel == r_activeSel) begin
                    w_nextState = SHOW;
                end else if (w_frameTick) begin
                    w_activeSelNext = r_targetSel;
                    if (BLANK_FRAMES == 0) begin
                        w_nextState  = SHOW;
                        w_switchDone = 1'b1;
                    end else begin
                        w_frameCntNext = BLANK_LOAD;
                        w_nextState    = BLANK;
                    end
                end
            end
            BLANK: begin
                // A new request during blanking restarts the black period on the new screen.
                if (w_frameTick) begin
                    if (bus.sel != r_activeSel) begin
                        w_activeSelNext = bus.sel;
                        w_frameCntNext  = BLANK_LOAD;
                    end else if (r_frameCnt == 8'd1) begin
                        w_nextState  = SHOW;
                        w_switchDone = 1'b1;
                    end else begin
                        w_frameCntNext = r_frameCnt - 8'd1;
                    end
                end
            end
            default: w_nextState = SHOW;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SHOW;
            r_activeSel  <= '0;
            r_targetSel  <= '0;
            r_frameCnt   <= '0;
            r_hcount     <= '0;
            r_vcount     <= '0;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_hblnk      <= 1'b0;
            r_vblnk      <= 1'b0;
            r_rgb        <= '0;
            r_busy       <= 1'b0;
            r_switchDone <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_activeSel  <= w_activeSelNext;
            r_targetSel  <= w_targetSelNext;
            r_frameCnt   <= w_frameCntNext;
            r_hcount     <= w_hcount;
            r_vcount     <= w_vcount;
            r_hsync      <= w_hsync;
            r_vsync      <= w_vsync;
            r_hblnk      <= w_hblnk;
            r_vblnk      <= w_vblnk;
            r_rgb        <= w_rgb;
            r_busy       <= (r_state != SHOW);
            r_switchDone <= w_switchDone;
        end
    end

    assign bus.out_hcount  = r_hcount;
    assign bus.out_vcount  = r_vcount;
    assign bus.out_hsync   = r_hsync;
    assign bus.out_vsync   = r_vsync;
    assign bus.out_hblnk   = r_hblnk;
    assign bus.out_vblnk   = r_vblnk;
    assign bus.out_rgb     = r_rgb;
    assign bus.busy        = r_busy;
    assign bus.switch_done = r_switchDone;

endmodule
